// File: rtl/input_buf_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : input_buf_ctrl_if
//  Description : Handshake bundle between one input FIFO, the crossbar
//                arbiter and the crossbar data path for input_buf_ctrl.
//                The master modport is the controller side; the slave
//                modport is the FIFO/arbiter/crossbar environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface input_buf_ctrl_if #(
  parameter int PORTS  = 4,
  parameter int FLIT_W = 16
);
  logic [FLIT_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_re;
  logic [PORTS-1:0]  req;
  logic              ack;
  logic [FLIT_W-1:0] out_flit;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              pkt_done;
  logic              err;
  logic [15:0]       pkt_cnt;

  modport master (
    input  fifo_dout, fifo_empty, ack, out_ready,
    output fifo_re, req, out_flit, out_valid, busy, pkt_done, err, pkt_cnt
  );

  modport slave (
    output fifo_dout, fifo_empty, ack, out_ready,
    input  fifo_re, req, out_flit, out_valid, busy, pkt_done, err, pkt_cnt
  );
endinterface
`default_nettype wire

// File: rtl/input_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : input_buf_ctrl
//  Description : Input-buffer controller for one switch input port. Decodes
//                the head flit destination into a one-hot arbiter request,
//                holds it until granted (with optional ack-timeout backoff),
//                streams the packet to the crossbar under backpressure and
//                drops malformed flits seen while idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_buf_ctrl #(
  parameter int PORTS       = 4,
  parameter int FLIT_W      = 16,
  parameter int DEST_W      = $clog2(PORTS),
  parameter int ACK_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input_buf_ctrl_if.master bus
);

  localparam logic [1:0] FT_SINGLE = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_BODY   = 2'b10;
  localparam logic [1:0] FT_TAIL   = 2'b11;

  // wait counter only ever reaches ACK_TIMEOUT-1
  localparam int              WAIT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);
  localparam logic [DEST_W:0]   PORTS_X   = (DEST_W + 1)'(PORTS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_BACKOFF = 3'd2,
    S_XFER    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PORTS-1:0]  req_q, req_d;
  logic [PORTS-1:0]  sav_q, sav_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;

  logic [1:0]        ftype;
  logic [DEST_W-1:0] dest;
  logic              hdr_ok;
  logic              is_last;
  logic              body_or_tail;
  logic [PORTS-1:0]  dest_oh;
  logic              fifo_re;
  logic              out_valid;
  logic              err;

  assign ftype        = bus.fifo_dout[FLIT_W-1 -: 2];
  assign dest         = bus.fifo_dout[DEST_W-1:0];
  assign body_or_tail = (ftype == FT_BODY) || (ftype == FT_TAIL);
  // a packet may only start on a HEAD/SINGLE flit addressing an existing port
  assign hdr_ok       = !body_or_tail && ({1'b0, dest} < PORTS_X);
  assign is_last      = (ftype == FT_TAIL) || (ftype == FT_SINGLE);
  assign dest_oh      = {{(PORTS-1){1'b0}}, 1'b1} << dest;

  // FIFO pop, crossbar valid and drop pulse; nothing moves while rst is high
  always_comb begin
    fifo_re   = 1'b0;
    out_valid = 1'b0;
    err       = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (!bus.fifo_empty && !hdr_ok) begin
            fifo_re = 1'b1;
            err     = 1'b1;
          end
        end
        S_XFER: begin
          out_valid = !bus.fifo_empty;
          fifo_re   = !bus.fifo_empty && bus.out_ready;
        end
        default: ;
      endcase
    end
  end

  // next-state, request and counter logic
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    sav_d     = sav_q;
    wait_d    = wait_q;
    pkt_cnt_d = pkt_cnt_q;
    case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (!bus.fifo_empty && hdr_ok) begin
          req_d   = dest_oh;
          sav_d   = dest_oh;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.ack) begin
          wait_d  = '0;
          state_d = S_XFER;
        end else if (ACK_TIMEOUT > 0) begin
          if (wait_q == WAIT_LAST) begin
            req_d   = '0;
            wait_d  = '0;
            state_d = S_BACKOFF;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
      end
      S_BACKOFF: begin
        req_d   = sav_q;
        wait_d  = '0;
        state_d = S_REQ;
      end
      S_XFER: begin
        // a mid-packet HEAD is just data here; only TAIL/SINGLE ends the packet
        if (fifo_re && is_last) begin
          req_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        req_d     = '0;
        pkt_cnt_d = pkt_cnt_q + 16'd1;
        state_d   = S_IDLE;
      end
      default: begin
        req_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // state registers; reset abandons any packet in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      sav_q     <= '0;
      wait_q    <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      sav_q     <= sav_d;
      wait_q    <= wait_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign bus.fifo_re   = fifo_re;
  assign bus.out_valid = out_valid;
  assign bus.out_flit  = bus.fifo_dout;
  assign bus.err       = err;
  assign bus.req       = req_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.pkt_done  = (state_q == S_DONE);
  assign bus.pkt_cnt   = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_input_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_buf_ctrl
//  Description : Self-checking bench for input_buf_ctrl. Instance 0 has four
//                ports and no ack timeout; instance 1 has three ports and
//                ACK_TIMEOUT=3. Directed steps cover the documented scenarios,
//                then random traffic is checked against a packet-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_buf_ctrl;
  localparam int NI = 2;
  localparam logic [1:0] T_S = 2'b00;
  localparam logic [1:0] T_H = 2'b01;
  localparam logic [1:0] T_B = 2'b10;
  localparam logic [1:0] T_T = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  input_buf_ctrl_if #(.PORTS(4), .FLIT_W(16)) ifc0 ();
  input_buf_ctrl_if #(.PORTS(3), .FLIT_W(16)) ifc1 ();

  input_buf_ctrl #(.PORTS(4), .FLIT_W(16), .DEST_W(2), .ACK_TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst), .bus(ifc0));
  input_buf_ctrl #(.PORTS(3), .FLIT_W(16), .DEST_W(2), .ACK_TIMEOUT(3)) dut1 (
    .clk(clk), .rst(rst), .bus(ifc1));

  // FIFO model (circular, 128 deep) and output sink per instance
  logic [15:0] fmem [NI][128];
  logic [6:0]  fhead [NI] = '{7'd0, 7'd0};
  logic [6:0]  ftail [NI] = '{7'd0, 7'd0};
  logic        ack_i [NI];
  logic        rdy_i [NI];
  logic        hold_e [NI];
  logic [15:0] omem [NI][1024];
  int          ocnt [NI] = '{0, 0};
  int          errs [NI] = '{0, 0};
  int          dones [NI] = '{0, 0};

  logic [3:0]  req_o [NI];
  logic        re_o [NI], ov_o [NI], busy_o [NI], done_o [NI], err_o [NI], emp_o [NI];
  logic [15:0] fl_o [NI], cnt_o [NI];

  assign ifc0.fifo_dout  = fmem[0][fhead[0]];
  assign ifc0.fifo_empty = (fhead[0] == ftail[0]) || hold_e[0];
  assign ifc0.ack        = ack_i[0];
  assign ifc0.out_ready  = rdy_i[0];
  assign ifc1.fifo_dout  = fmem[1][fhead[1]];
  assign ifc1.fifo_empty = (fhead[1] == ftail[1]) || hold_e[1];
  assign ifc1.ack        = ack_i[1];
  assign ifc1.out_ready  = rdy_i[1];

  assign req_o[0]  = ifc0.req;          assign req_o[1]  = {1'b0, ifc1.req};
  assign re_o[0]   = ifc0.fifo_re;      assign re_o[1]   = ifc1.fifo_re;
  assign ov_o[0]   = ifc0.out_valid;    assign ov_o[1]   = ifc1.out_valid;
  assign busy_o[0] = ifc0.busy;         assign busy_o[1] = ifc1.busy;
  assign done_o[0] = ifc0.pkt_done;     assign done_o[1] = ifc1.pkt_done;
  assign err_o[0]  = ifc0.err;          assign err_o[1]  = ifc1.err;
  assign emp_o[0]  = ifc0.fifo_empty;   assign emp_o[1]  = ifc1.fifo_empty;
  assign fl_o[0]   = ifc0.out_flit;     assign fl_o[1]   = ifc1.out_flit;
  assign cnt_o[0]  = ifc0.pkt_cnt;      assign cnt_o[1]  = ifc1.pkt_cnt;

  // FIFO pops, accepted flits, err and pkt_done pulses
  always @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (re_o[k] && !emp_o[k]) fhead[k] <= fhead[k] + 7'd1;
      if (ov_o[k] && rdy_i[k]) begin
        omem[k][ocnt[k] % 1024] <= fl_o[k];
        ocnt[k] <= ocnt[k] + 1;
      end
      if (err_o[k])  errs[k]  <= errs[k] + 1;
      if (done_o[k]) dones[k] <= dones[k] + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [15:0] f);
    fmem[k][ftail[k]] = f;
    ftail[k] = ftail[k] + 7'd1;
  endtask

  function automatic logic [15:0] mk(input logic [1:0] t, input int d);
    logic [11:0] p;
    p = 12'($urandom);
    return {t, p, 2'(d)};
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin : main
    logic [15:0] f [4];
    int exp_cnt [NI];
    int o0 [NI];
    int e0 [NI];
    int d0 [NI];
    int t4_rdy [9];
    int t4_hold [9];
    int t4_re [9];
    int t4_ov [9];
    logic [15:0] exp_s [NI][128];
    int exp_n [NI];
    int pk_start [NI][32];
    int pk_dest [NI][32];
    int npk [NI];
    int nstray [NI];
    bit finished;

    for (int k = 0; k < NI; k++) begin
      ack_i[k] = 1'b0; rdy_i[k] = 1'b1; hold_e[k] = 1'b0;
    end

    // ---------------- reset state ----------------
    rst = 1'b1;
    nxt(); nxt();
    rst = 1'b0;
    settle();
    chk("rst_req0", req_o[0], 0);
    chk("rst_req1", req_o[1], 0);
    chk("rst_busy0", busy_o[0], 0);
    chk("rst_cnt0", cnt_o[0], 0);
    chk("rst_ov0", ov_o[0], 0);
    chk("rst_re0", re_o[0], 0);
    exp_cnt[0] = 0; exp_cnt[1] = 0;

    // ---------------- 3-flit packet, dest 2, ack one cycle after req ----------------
    nxt();
    f[0] = mk(T_H, 2); f[1] = mk(T_B, $urandom); f[2] = mk(T_T, $urandom);
    o0[0] = ocnt[0]; d0[0] = dones[0];
    for (int i = 0; i < 3; i++) push(0, f[i]);
    settle();
    chk("t1_c0_req", req_o[0], 0);
    chk("t1_c0_re", re_o[0], 0);
    for (int c = 1; c <= 6; c++) begin
      nxt();
      ack_i[0] = (c == 2);
      settle();
      chk("t1_req", req_o[0], (c <= 5) ? 4 : 0);
      chk("t1_re", re_o[0], (c >= 3 && c <= 5));
      chk("t1_done", done_o[0], (c == 6));
    end
    ack_i[0] = 1'b0;
    nxt(); settle();
    exp_cnt[0] = 1;
    chk("t1_cnt", cnt_o[0], exp_cnt[0]);
    chk("t1_nflit", ocnt[0] - o0[0], 3);
    for (int i = 0; i < 3; i++) chk("t1_flit", omem[0][o0[0] + i], f[i]);
    chk("t1_ndone", dones[0] - d0[0], 1);

    // ---------------- SINGLE dest 3, ack after 5 cycles, no timeout ----------------
    nxt();
    f[0] = mk(T_S, 3);
    o0[0] = ocnt[0];
    push(0, f[0]);
    settle();
    for (int c = 1; c <= 8; c++) begin
      nxt();
      ack_i[0] = (c == 6);
      settle();
      chk("t2_req", req_o[0], (c <= 7) ? 8 : 0);
      chk("t2_re", re_o[0], (c == 7));
      chk("t2_done", done_o[0], (c == 8));
    end
    ack_i[0] = 1'b0;
    nxt(); settle();
    exp_cnt[0] = 2;
    chk("t2_cnt", cnt_o[0], exp_cnt[0]);
    chk("t2_nflit", ocnt[0] - o0[0], 1);
    chk("t2_flit", omem[0][o0[0]], f[0]);

    // ---------------- backpressure and FIFO underrun mid-packet ----------------
    t4_rdy  = '{1, 0, 0, 1, 1, 1, 1, 1, 1};
    t4_hold = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
    t4_re   = '{1, 0, 0, 1, 0, 0, 1, 1, 0};
    t4_ov   = '{1, 1, 1, 1, 0, 0, 1, 1, 0};
    nxt();
    f[0] = mk(T_H, 1); f[1] = mk(T_B, $urandom); f[2] = mk(T_B, $urandom); f[3] = mk(T_T, $urandom);
    o0[0] = ocnt[0]; d0[0] = dones[0];
    for (int i = 0; i < 4; i++) push(0, f[i]);
    settle();
    for (int c = 1; c <= 10; c++) begin
      nxt();
      ack_i[0] = (c == 1);
      if (c >= 2) begin
        rdy_i[0]  = (t4_rdy[c-2] != 0);
        hold_e[0] = (t4_hold[c-2] != 0);
      end
      settle();
      chk("t4_req", req_o[0], (c <= 9) ? 2 : 0);
      if (c >= 2) begin
        chk("t4_re", re_o[0], t4_re[c-2]);
        chk("t4_ov", ov_o[0], t4_ov[c-2]);
      end
      chk("t4_done", done_o[0], (c == 10));
    end
    rdy_i[0] = 1'b1; hold_e[0] = 1'b0; ack_i[0] = 1'b0;
    nxt(); settle();
    exp_cnt[0] = 3;
    chk("t4_cnt", cnt_o[0], exp_cnt[0]);
    chk("t4_nflit", ocnt[0] - o0[0], 4);
    for (int i = 0; i < 4; i++) chk("t4_flit", omem[0][o0[0] + i], f[i]);
    chk("t4_ndone", dones[0] - d0[0], 1);

    // ---------------- ack timeout backoff (instance 1, ACK_TIMEOUT=3) ----------------
    nxt();
    f[0] = mk(T_H, 2); f[1] = mk(T_T, $urandom);
    o0[1] = ocnt[1];
    push(1, f[0]); push(1, f[1]);
    settle();
    for (int c = 1; c <= 14; c++) begin
      nxt();
      ack_i[1] = (c == 11);
      settle();
      if (c <= 11) chk("t3_req", req_o[1], (((c - 1) % 4) == 3) ? 0 : 4);
      else         chk("t3_req", req_o[1], (c <= 13) ? 4 : 0);
      chk("t3_busy", busy_o[1], 1);
      chk("t3_re", re_o[1], (c == 12 || c == 13));
      chk("t3_done", done_o[1], (c == 14));
    end
    ack_i[1] = 1'b0;
    nxt(); settle();
    exp_cnt[1] = 1;
    chk("t3_cnt", cnt_o[1], exp_cnt[1]);
    chk("t3_nflit", ocnt[1] - o0[1], 2);
    chk("t3_flit0", omem[1][o0[1]], f[0]);
    chk("t3_flit1", omem[1][o0[1] + 1], f[1]);

    // ---------------- stray BODY and out-of-range HEAD (PORTS=3) ----------------
    nxt();
    e0[1] = errs[1];
    push(1, mk(T_B, 1));
    push(1, mk(T_H, 3));
    settle();
    for (int c = 0; c <= 2; c++) begin
      if (c > 0) begin nxt(); settle(); end
      chk("t5_re", re_o[1], (c <= 1));
      chk("t5_err", err_o[1], (c <= 1));
      chk("t5_req", req_o[1], 0);
    end
    chk("t5_nerr", errs[1] - e0[1], 2);
    chk("t5_cnt", cnt_o[1], exp_cnt[1]);
    chk("t5_busy", busy_o[1], 0);

    // ---------------- reset during transfer ----------------
    nxt();
    f[0] = mk(T_H, 0); f[1] = mk(T_B, $urandom); f[2] = mk(T_B, $urandom); f[3] = mk(T_T, $urandom);
    o0[0] = ocnt[0]; e0[0] = errs[0];
    for (int i = 0; i < 4; i++) push(0, f[i]);
    settle();
    nxt(); ack_i[0] = 1'b1; settle();
    nxt(); ack_i[0] = 1'b0; settle();
    chk("t6_re_h", re_o[0], 1);
    nxt(); settle();
    chk("t6_re_b", re_o[0], 1);
    nxt(); rst = 1'b1; settle();
    chk("t6_rst_re", re_o[0], 0);
    chk("t6_rst_ov", ov_o[0], 0);
    nxt(); settle();
    chk("t6_req", req_o[0], 0);
    chk("t6_busy", busy_o[0], 0);
    chk("t6_done", done_o[0], 0);
    chk("t6_err", err_o[0], 0);
    chk("t6_re", re_o[0], 0);
    chk("t6_ov", ov_o[0], 0);
    chk("t6_cnt0", cnt_o[0], 0);
    chk("t6_cnt1", cnt_o[1], 0);
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    nxt(); rst = 1'b0; settle();
    chk("t6_drop_b", err_o[0], 1);
    chk("t6_drop_b_req", req_o[0], 0);
    nxt(); settle();
    chk("t6_drop_t", err_o[0], 1);
    nxt(); settle();
    chk("t6_idle_re", re_o[0], 0);
    chk("t6_nerr", errs[0] - e0[0], 2);
    chk("t6_nflit", ocnt[0] - o0[0], 2);
    chk("t6_cnt_after", cnt_o[0], 0);

    // ---------------- random traffic against a packet-level model ----------------
    for (int k = 0; k < NI; k++) begin
      exp_n[k] = 0; npk[k] = 0; nstray[k] = 0;
      o0[k] = ocnt[k]; e0[k] = errs[k]; d0[k] = dones[k];
      for (int it = 0; it < 16; it++) begin
        if ($urandom_range(0, 3) == 0) begin
          int s;
          s = (k == 1) ? $urandom_range(0, 2) : $urandom_range(0, 1);
          if (s == 0)      push(k, mk(T_B, $urandom));
          else if (s == 1) push(k, mk(T_T, $urandom));
          else             push(k, mk(T_H, 3));
          nstray[k]++;
        end else begin
          int d, len;
          logic [15:0] fl;
          d   = (k == 1) ? $urandom_range(0, 2) : $urandom_range(0, 3);
          len = $urandom_range(1, 4);
          pk_start[k][npk[k]] = exp_n[k];
          pk_dest[k][npk[k]]  = d;
          npk[k]++;
          for (int j = 0; j < len; j++) begin
            if (len == 1)                fl = mk(T_S, d);
            else if (j == 0)             fl = mk(T_H, d);
            else if (j == len - 1)       fl = mk(T_T, $urandom);
            else if ($urandom_range(0, 3) == 0) fl = mk(T_H, $urandom);
            else                         fl = mk(T_B, $urandom);
            exp_s[k][exp_n[k]] = fl;
            exp_n[k]++;
            push(k, fl);
          end
        end
      end
    end

    finished = 1'b0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      nxt();
      for (int k = 0; k < NI; k++) begin
        ack_i[k]  = ($urandom_range(0, 1) == 1);
        rdy_i[k]  = ($urandom_range(0, 3) != 0);
        hold_e[k] = ($urandom_range(0, 9) == 0);
      end
      settle();
      finished = 1'b1;
      for (int k = 0; k < NI; k++) begin
        int idx, p;
        logic [3:0] oh;
        chk("rnd_re_empty", re_o[k] && emp_o[k], 0);
        if (ov_o[k]) chk("rnd_passthru", fl_o[k], fmem[k][fhead[k]]);
        idx = ocnt[k] - o0[k];
        if (idx < exp_n[k]) begin
          p = 0;
          for (int j = 0; j < npk[k]; j++) if (pk_start[k][j] <= idx) p = j;
          oh = 4'(1 << pk_dest[k][p]);
          chk("rnd_req", (req_o[k] == 4'd0) || (req_o[k] == oh), 1);
        end else begin
          chk("rnd_req_idle", req_o[k], 0);
        end
        if (fhead[k] != ftail[k] || busy_o[k]) finished = 1'b0;
      end
    end
    chk("rnd_timeout", finished, 1);
    for (int k = 0; k < NI; k++) begin
      ack_i[k] = 1'b0; rdy_i[k] = 1'b1; hold_e[k] = 1'b0;
      chk("rnd_nflit", ocnt[k] - o0[k], exp_n[k]);
      for (int i = 0; i < exp_n[k] && i < ocnt[k] - o0[k]; i++)
        chk("rnd_flit", omem[k][(o0[k] + i) % 1024], exp_s[k][i]);
      chk("rnd_ndone", dones[k] - d0[k], npk[k]);
      chk("rnd_nerr", errs[k] - e0[k], nstray[k]);
      chk("rnd_cnt", cnt_o[k], exp_cnt[k] + npk[k]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
